// File: rtl/scene_loader.sv
// scene_loader: framed scene upload receiver that sits in front of scene_buffer.
// It takes a byte stream (HEADER_BYTE, N, N object records, CHK), assembles each record
// and writes it to one scene_buffer slot. The object count is committed only if the
// packet checksum matches.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-low
//   rx_valid       one-cycle strobe: rx_data holds a new byte
//   rx_data        received byte
//   flash_obj_wen  one-cycle write strobe to scene_buffer
//   flash_obj_idx  object slot being written (held when wen=0)
//   flash_obj_data assembled object record (held when wen=0)
//   num_objs       committed object count
//   load_busy      high whenever the FSM is not idle
//   load_done      one-cycle pulse: packet accepted, num_objs updated
//   load_err       one-cycle pulse: packet rejected (bad count, checksum or timeout)
module scene_loader #(
  parameter int unsigned OBJ_BITS       = 384,
  parameter int unsigned MAX_NUM_OBJS   = 64,
  parameter int unsigned OBJ_IDX_WIDTH  = 6,
  parameter logic [7:0]  HEADER_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RESET_NUM_OBJS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     flash_obj_wen,
  output logic [OBJ_IDX_WIDTH-1:0] flash_obj_idx,
  output logic [OBJ_BITS-1:0]      flash_obj_data,
  output logic [OBJ_IDX_WIDTH-1:0] num_objs,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     load_err
);

  localparam int unsigned Bytes    = (OBJ_BITS + 7) / 8;
  localparam int unsigned SregW    = Bytes * 8;
  localparam int unsigned ByteCntW = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam int unsigned TmoW     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StCount, StPayload, StCheck} state_e;

  state_e              state;
  logic [SregW-1:0]    sreg;
  logic [SregW-1:0]    sreg_nxt;
  logic [ByteCntW-1:0] byte_cnt;
  logic [7:0]          obj_cnt;
  logic [7:0]          n_objs;
  logic [7:0]          chk_acc;
  logic [TmoW-1:0]     tmo_cnt;
  logic                tmo_hit;

  // Records arrive LSB byte first: new bytes enter at the top and move down, so after
  // Bytes shifts byte k sits at [8k+7:8k].
  always_comb begin
    sreg_nxt = SregW'({rx_data, sreg} >> 8);
  end

  // An accepted byte in the expiry cycle suppresses the timeout.
  assign tmo_hit   = !rx_valid && (state != StIdle) && (tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1));
  assign load_busy = (state != StIdle);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= StIdle;
      sreg           <= '0;
      byte_cnt       <= '0;
      obj_cnt        <= '0;
      n_objs         <= '0;
      chk_acc        <= '0;
      tmo_cnt        <= '0;
      flash_obj_wen  <= 1'b0;
      flash_obj_idx  <= '0;
      flash_obj_data <= '0;
      num_objs       <= OBJ_IDX_WIDTH'(RESET_NUM_OBJS);
      load_done      <= 1'b0;
      load_err       <= 1'b0;
    end else begin
      flash_obj_wen <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;

      if (rx_valid || state == StIdle) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TmoW'(1);
      end

      if (tmo_hit) begin
        state    <= StIdle;
        load_err <= 1'b1;
        tmo_cnt  <= '0;
      end else if (rx_valid) begin
        unique case (state)
          StIdle: begin
            if (rx_data == HEADER_BYTE) state <= StCount;
          end
          StCount: begin
            n_objs   <= rx_data;
            chk_acc  <= rx_data;
            obj_cnt  <= '0;
            byte_cnt <= '0;
            if (rx_data == 8'd0 || rx_data > 8'(MAX_NUM_OBJS)) begin
              state    <= StIdle;
              load_err <= 1'b1;
            end else begin
              state <= StPayload;
            end
          end
          StPayload: begin
            sreg    <= sreg_nxt;
            chk_acc <= chk_acc ^ rx_data;
            if (byte_cnt == ByteCntW'(Bytes - 1)) begin
              flash_obj_wen  <= 1'b1;
              flash_obj_idx  <= obj_cnt[OBJ_IDX_WIDTH-1:0];
              flash_obj_data <= sreg_nxt[OBJ_BITS-1:0];
              byte_cnt       <= '0;
              obj_cnt        <= obj_cnt + 8'd1;
              if (obj_cnt == n_objs - 8'd1) state <= StCheck;
            end else begin
              byte_cnt <= byte_cnt + ByteCntW'(1);
            end
          end
          StCheck: begin
            // Earlier writes are intentionally left in place on a mismatch.
            if (rx_data == chk_acc) begin
              num_objs  <= n_objs[OBJ_IDX_WIDTH-1:0];
              load_done <= 1'b1;
            end else begin
              load_err <= 1'b1;
            end
            state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scene_loader.sv
module tb_scene_loader;

  localparam int unsigned ObjBits = 16;
  localparam int unsigned MaxObjs = 64;
  localparam int unsigned IdxW    = 6;
  localparam int unsigned Tmo     = 8;

  localparam logic [2:0] KWr   = 3'b100;
  localparam logic [2:0] KDone = 3'b010;
  localparam logic [2:0] KErr  = 3'b001;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               rx_valid = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               flash_obj_wen;
  logic [IdxW-1:0]    flash_obj_idx;
  logic [ObjBits-1:0] flash_obj_data;
  logic [IdxW-1:0]    num_objs;
  logic               load_busy;
  logic               load_done;
  logic               load_err;

  scene_loader #(
    .OBJ_BITS      (ObjBits),
    .MAX_NUM_OBJS  (MaxObjs),
    .OBJ_IDX_WIDTH (IdxW),
    .HEADER_BYTE   (8'hA5),
    .TIMEOUT_CYCLES(Tmo),
    .RESET_NUM_OBJS(1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .flash_obj_wen (flash_obj_wen),
    .flash_obj_idx (flash_obj_idx),
    .flash_obj_data(flash_obj_data),
    .num_objs      (num_objs),
    .load_busy     (load_busy),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]         kind;
    logic [IdxW-1:0]    idx;
    logic [ObjBits-1:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] pl[$];
  logic [IdxW-1:0] exp_num = IdxW'(1);
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every strobe must match the next expected event; overlapping strobes give a bad kind.
  always @(negedge clk) begin : mon
    logic [2:0] k;
    ev_t e;
    k = {flash_obj_wen, load_done, load_err};
    if (rst && k != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'(k), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 64'(k), 64'(e.kind));
        if (e.kind == KWr) begin
          check("wr_idx", 64'(flash_obj_idx), 64'(e.idx));
          check("wr_data", 64'(flash_obj_data), 64'(e.data));
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [2:0] kind, input logic [IdxW-1:0] idx,
                      input logic [ObjBits-1:0] data);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    idle(4);
    check({tag, "_busy"}, 64'(load_busy), 64'(0));
    check({tag, "_num_objs"}, 64'(num_objs), 64'(exp_num));
  endtask

  // Sends A5, n, payload from pl (two bytes per object), then a good or corrupted CHK.
  task automatic load(input logic [7:0] n, input bit good);
    logic [7:0] chk;
    logic [7:0] prev;
    chk  = n;
    prev = 8'h00;
    send(8'hA5);
    send(n);
    for (int i = 0; i < pl.size(); i++) begin
      chk = chk ^ pl[i];
      if ((i % 2) == 1) push(KWr, IdxW'(i / 2), {pl[i], prev});
      prev = pl[i];
      send(pl[i]);
    end
    if (good) begin
      push(KDone, '0, '0);
      exp_num = n[IdxW-1:0];
      send(chk);
    end else begin
      push(KErr, '0, '0);
      send(chk ^ 8'h01);
    end
  endtask

  initial begin
    // Reset held for three cycles
    rst = 1'b0;
    idle(3);
    check("rst_num_objs", 64'(num_objs), 64'(1));
    check("rst_strobes", 64'({flash_obj_wen, load_done, load_err}), 64'(0));
    check("rst_busy", 64'(load_busy), 64'(0));
    check("rst_idx", 64'(flash_obj_idx), 64'(0));
    check("rst_data", 64'(flash_obj_data), 64'(0));
    rst = 1'b1;
    idle(2);

    // Noise in idle
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    check("noise_busy_now", 64'(load_busy), 64'(0));
    drain("noise");

    // Good packet: A5 02 11 22 33 44 46
    pl = {8'h11, 8'h22, 8'h33, 8'h44};
    load(8'd2, 1'b1);
    drain("good");

    // Same packet, bad checksum: writes land, count unchanged
    load(8'd2, 1'b0);
    drain("badchk");

    // Bad counts
    send(8'hA5);
    push(KErr, '0, '0);
    send(8'h00);
    drain("cnt0");
    send(8'hA5);
    push(KErr, '0, '0);
    send(8'(MaxObjs + 1));
    drain("cnt_over");

    // Timeout after 8 silent cycles mid-record
    send(8'hA5);
    send(8'h01);
    send(8'h11);
    push(KErr, '0, '0);
    idle(Tmo);
    drain("timeout");

    // Byte arrives exactly on the 8th silent cycle: no timeout
    send(8'hA5);
    send(8'h01);
    send(8'h11);
    idle(Tmo - 2);
    push(KWr, '0, 16'h2211);
    send(8'h22);
    push(KDone, '0, '0);
    exp_num = IdxW'(1);
    send(8'h01 ^ 8'h11 ^ 8'h22);
    drain("no_timeout");

    // Load N=2 again so the reset below is observable on num_objs
    pl = {8'h11, 8'h22, 8'h33, 8'h44};
    load(8'd2, 1'b1);
    drain("reload");

    // Reset mid-payload aborts silently
    send(8'hA5);
    send(8'h02);
    send(8'h11);
    push(KWr, '0, 16'h2211);
    send(8'h22);
    send(8'h33);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    exp_num = IdxW'(1);
    drain("mid_reset");

    // Clean load afterwards, with header value inside the payload
    pl = {8'hA5, 8'h01, 8'h02, 8'hA5, 8'hFF, 8'h00};
    load(8'd3, 1'b1);
    drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
